// File: rtl/conv_seq_ctrl_if.sv
// Control/config bundle between the convolution sequencer and its
// surroundings: top-state, loop config, MAC-array strobes and indices.
interface conv_seq_ctrl_if #(
    parameter int CNT_WIDTH   = 10,
    parameter int SCALE_WIDTH = 4
);
    logic [2:0]             current_state;
    logic [CNT_WIDTH-1:0]   cfg_ic_blk;
    logic [CNT_WIDTH-1:0]   cfg_oc_blk;
    logic [CNT_WIDTH-1:0]   cfg_pix;
    logic [SCALE_WIDTH-1:0] cfg_scale;
    logic                   fm_valid;
    logic                   out_ready;
    logic                   mac_en;
    logic                   adder_rst;
    logic                   acc_valid;
    logic [SCALE_WIDTH-1:0] scale_in;
    logic [CNT_WIDTH-1:0]   ic_cnt;
    logic [CNT_WIDTH-1:0]   pix_cnt;
    logic [CNT_WIDTH-1:0]   oc_cnt;
    logic                   busy;
    logic                   state_end;

    modport master (
        output current_state, cfg_ic_blk, cfg_oc_blk, cfg_pix, cfg_scale,
        output fm_valid, out_ready,
        input  mac_en, adder_rst, acc_valid, scale_in,
        input  ic_cnt, pix_cnt, oc_cnt, busy, state_end
    );

    modport slave (
        input  current_state, cfg_ic_blk, cfg_oc_blk, cfg_pix, cfg_scale,
        input  fm_valid, out_ready,
        output mac_en, adder_rst, acc_valid, scale_in,
        output ic_cnt, pix_cnt, oc_cnt, busy, state_end
    );
endinterface

// File: rtl/conv_seq_ctrl.sv
// Convolution loop sequencer: ic/pix/oc nest, accumulator strobes, drain.
// Optional macro CONV_CTRL_ABORT_EN: leaving CONV_STATE mid-run aborts to IDLE.
module conv_seq_ctrl #(
    parameter int         MAC_IN_NUM          = 9,
    parameter int         MAC_OUT_NUM         = 18,
    parameter int         CNT_WIDTH           = 10,
    parameter int         SCALE_WIDTH         = 4,
    parameter int         MULT_PIPELINE_STAGE = 2,
    parameter logic [2:0] CONV_STATE          = 3'd2
) (
    input logic           clk,
    input logic           rst,
    conv_seq_ctrl_if.slave bus
);
    localparam int DLY = MULT_PIPELINE_STAGE + 1;
    localparam int DW  = $clog2(DLY + 1);

    if (MAC_IN_NUM < 1 || MAC_OUT_NUM < 1 || MULT_PIPELINE_STAGE < 0) begin : g_bad_cfg
        $error("conv_seq_ctrl: invalid parameters");
    end

    typedef enum logic [2:0] {
        IDLE, LOAD, RUN, DRAIN, DONE
    } state_t;

    state_t                 state, state_nx;
    logic [CNT_WIDTH-1:0]   ic_q, pix_q, oc_q;
    logic [CNT_WIDTH-1:0]   ic_nx, pix_nx, oc_nx;
    logic [CNT_WIDTH-1:0]   ic_max, pix_max, oc_max;
    logic [SCALE_WIDTH-1:0] scale_q;
    logic [DLY-1:0]         pipe_q, pipe_nx;
    logic [DW-1:0]          drain_q, drain_nx;
    logic                   armed_q, armed_nx;
    logic                   conv_sel, abort, beat;

    assign conv_sel = (bus.current_state == CONV_STATE);
    assign beat     = (state == RUN) & bus.fm_valid & bus.out_ready;

`ifdef CONV_CTRL_ABORT_EN
    assign abort = !conv_sel && (state == LOAD || state == RUN || state == DRAIN);
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        ic_nx    = ic_q;
        pix_nx   = pix_q;
        oc_nx    = oc_q;
        drain_nx = drain_q;
        // armed re-opens only once the top state has been seen outside CONV
        armed_nx = armed_q | ~conv_sel;
        pipe_nx[0] = beat & (ic_q == ic_max);
        for (int i = 1; i < DLY; i++) pipe_nx[i] = pipe_q[i-1];

        unique case (state)
            IDLE: begin
                if (conv_sel && armed_q) begin
                    state_nx = LOAD;
                    armed_nx = 1'b0;
                end
            end
            LOAD: begin
                state_nx = RUN;
                ic_nx    = '0;
                pix_nx   = '0;
                oc_nx    = '0;
            end
            RUN: begin
                if (beat) begin
                    if (ic_q == ic_max) begin
                        ic_nx = '0;
                        if (pix_q == pix_max) begin
                            pix_nx = '0;
                            if (oc_q == oc_max) begin
                                oc_nx    = '0;
                                drain_nx = '0;
                                state_nx = DRAIN;
                            end else begin
                                oc_nx = oc_q + CNT_WIDTH'(1);
                            end
                        end else begin
                            pix_nx = pix_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        ic_nx = ic_q + CNT_WIDTH'(1);
                    end
                end
            end
            DRAIN: begin
                drain_nx = drain_q + DW'(1);
                if (drain_q == DW'(DLY - 1)) begin
                    drain_nx = '0;
                    state_nx = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase

        if (abort) begin
            state_nx = IDLE;
            ic_nx    = '0;
            pix_nx   = '0;
            oc_nx    = '0;
            drain_nx = '0;
            pipe_nx  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ic_q    <= '0;
            pix_q   <= '0;
            oc_q    <= '0;
            drain_q <= '0;
            pipe_q  <= '0;
            armed_q <= 1'b1;
            ic_max  <= '0;
            pix_max <= '0;
            oc_max  <= '0;
            scale_q <= '0;
        end else begin
            state   <= state_nx;
            ic_q    <= ic_nx;
            pix_q   <= pix_nx;
            oc_q    <= oc_nx;
            drain_q <= drain_nx;
            pipe_q  <= pipe_nx;
            armed_q <= armed_nx;
            if (state == LOAD) begin
                ic_max  <= bus.cfg_ic_blk;
                pix_max <= bus.cfg_pix;
                oc_max  <= bus.cfg_oc_blk;
                scale_q <= bus.cfg_scale;
            end
        end
    end

    assign bus.mac_en    = beat;
    assign bus.adder_rst = beat & (ic_q == '0);
    assign bus.acc_valid = pipe_q[DLY-1];
    assign bus.scale_in  = scale_q;
    assign bus.ic_cnt    = ic_q;
    assign bus.pix_cnt   = pix_q;
    assign bus.oc_cnt    = oc_q;
    assign bus.busy      = (state != IDLE);
    assign bus.state_end = (state == DONE);
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl: directed runs, expected events queued
// with cycle offsets relative to the cycle CONV_STATE was raised.
module tb_conv_seq_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;

    conv_seq_ctrl_if #(.CNT_WIDTH(10), .SCALE_WIDTH(4)) bus ();

    conv_seq_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc      = 0;
    int t0       = 0;
    int checks   = 0;
    int failures = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // kind: 0 = mac beat (a/b/c = ic/pix/oc, d = adder_rst)
    //       1 = acc_valid (d = scale_in), 2 = state_end
    typedef struct packed {
        int kind;
        int rel;
        int a;
        int b;
        int c;
        int d;
    } ev_t;

    ev_t exp_q[$];

    function automatic ev_t mk(int kind, int rel, int a, int b, int c, int d);
        ev_t e;
        e.kind = kind;
        e.rel  = rel;
        e.a    = a;
        e.b    = b;
        e.c    = c;
        e.d    = d;
        return e;
    endfunction

    task automatic push(int kind, int rel, int a, int b, int c, int d);
        exp_q.push_back(mk(kind, rel, a, b, c, d));
    endtask

    task automatic score(input ev_t o);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event got kind=%0d rel=%0d a/b/c/d=%0d/%0d/%0d/%0d required none",
                     o.kind, o.rel, o.a, o.b, o.c, o.d);
        end else begin
            e = exp_q.pop_front();
            if (e !== o) begin
                failures++;
                $display("FAIL event got kind=%0d rel=%0d a/b/c/d=%0d/%0d/%0d/%0d required kind=%0d rel=%0d a/b/c/d=%0d/%0d/%0d/%0d",
                         o.kind, o.rel, o.a, o.b, o.c, o.d,
                         e.kind, e.rel, e.a, e.b, e.c, e.d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mac_en)
                score(mk(0, cyc - t0, int'(bus.ic_cnt), int'(bus.pix_cnt),
                         int'(bus.oc_cnt), int'(bus.adder_rst)));
            if (bus.acc_valid)
                score(mk(1, cyc - t0, 0, 0, 0, int'(bus.scale_in)));
            if (bus.state_end)
                score(mk(2, cyc - t0, 0, 0, 0, 0));
        end
    end

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s got %0d required %0d", name, act, req);
        end
    endtask

    task automatic check_empty(string name);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_missing got %0d pending events required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rel(int n);
        while (cyc - t0 < n) step();
    endtask

    task automatic start_run(int ic, int pix, int oc, int sc);
        step();
        bus.cfg_ic_blk    = 10'(ic);
        bus.cfg_pix       = 10'(pix);
        bus.cfg_oc_blk    = 10'(oc);
        bus.cfg_scale     = 4'(sc);
        bus.fm_valid      = 1'b1;
        bus.out_ready     = 1'b1;
        bus.current_state = 3'd2;
        t0 = cyc;
    endtask

    task automatic finish_run(string name);
        wait_rel(20);
        check_empty(name);
        bus.current_state = 3'd0;
        step();
        step();
    endtask

    // 3 ic x 2 pix x 1 oc, beats at the given offsets
    task automatic exp_basic(int b0, int b1, int b2, int b3, int b4, int b5, int sc);
        push(0, b0, 0, 0, 0, 1);
        push(0, b1, 1, 0, 0, 0);
        push(0, b2, 2, 0, 0, 0);
        push(0, b3, 0, 1, 0, 1);
        push(0, b4, 1, 1, 0, 0);
        push(0, b5, 2, 1, 0, 0);
        push(1, b2 + 3, 0, 0, 0, sc);
        push(1, b5 + 3, 0, 0, 0, sc);
        push(2, b5 + 4, 0, 0, 0, 0);
    endtask

    initial begin
        bus.current_state = 3'd0;
        bus.cfg_ic_blk    = '0;
        bus.cfg_pix       = '0;
        bus.cfg_oc_blk    = '0;
        bus.cfg_scale     = '0;
        bus.fm_valid      = 1'b0;
        bus.out_ready     = 1'b0;

        #2;
        chk("rst_mac_en",    int'(bus.mac_en),    0);
        chk("rst_adder_rst", int'(bus.adder_rst), 0);
        chk("rst_acc_valid", int'(bus.acc_valid), 0);
        chk("rst_scale_in",  int'(bus.scale_in),  0);
        chk("rst_ic_cnt",    int'(bus.ic_cnt),    0);
        chk("rst_pix_cnt",   int'(bus.pix_cnt),   0);
        chk("rst_oc_cnt",    int'(bus.oc_cnt),    0);
        chk("rst_busy",      int'(bus.busy),      0);
        chk("rst_state_end", int'(bus.state_end), 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        step();

        // basic run; cfg changed after LOAD must not matter
        start_run(2, 1, 0, 3);
        exp_basic(2, 3, 4, 5, 6, 7, 3);
        wait_rel(3);
        bus.cfg_ic_blk = 10'd0;
        bus.cfg_pix    = 10'd3;
        bus.cfg_scale  = 4'd9;
        finish_run("basic");

        // fm_valid low for 4 cycles after beat 2
        start_run(2, 1, 0, 3);
        exp_basic(2, 3, 8, 9, 10, 11, 3);
        wait_rel(4);
        bus.fm_valid = 1'b0;
        wait_rel(5);
        chk("stall_ic_hold",  int'(bus.ic_cnt),  2);
        chk("stall_pix_hold", int'(bus.pix_cnt), 0);
        chk("stall_busy",     int'(bus.busy),    1);
        wait_rel(8);
        bus.fm_valid = 1'b1;
        finish_run("stall");

        // all-zero config, scale 5
        start_run(0, 0, 0, 5);
        push(0, 2, 0, 0, 0, 1);
        push(1, 5, 0, 0, 0, 5);
        push(2, 6, 0, 0, 0, 0);
        finish_run("min_cfg");

        // reset at beat 3
        start_run(2, 1, 0, 3);
        push(0, 2, 0, 0, 0, 1);
        push(0, 3, 1, 0, 0, 0);
        wait_rel(4);
        rst = 1'b1;
        #1;
        chk("mrst_mac_en",    int'(bus.mac_en),    0);
        chk("mrst_adder_rst", int'(bus.adder_rst), 0);
        chk("mrst_ic_cnt",    int'(bus.ic_cnt),    0);
        chk("mrst_scale_in",  int'(bus.scale_in),  0);
        chk("mrst_busy",      int'(bus.busy),      0);
        bus.current_state = 3'd0;
        step();
        step();
        rst = 1'b0;
        wait_rel(20);
        check_empty("mid_reset");
        chk("mrst_idle_after", int'(bus.busy), 0);

        // current_state drops at beat 2
        start_run(2, 1, 0, 3);
`ifdef CONV_CTRL_ABORT_EN
        push(0, 2, 0, 0, 0, 1);
        push(0, 3, 1, 0, 0, 0);
        wait_rel(3);
        bus.current_state = 3'd0;
        wait_rel(4);
        chk("abort_busy", int'(bus.busy), 0);
        chk("abort_ic",   int'(bus.ic_cnt), 0);
`else
        exp_basic(2, 3, 4, 5, 6, 7, 3);
        wait_rel(3);
        bus.current_state = 3'd0;
        wait_rel(4);
        chk("noabort_busy", int'(bus.busy), 1);
`endif
        finish_run("abort");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/conv_seq_ctrl.md
CONV_SEQ_CTRL -- requirements
Module: conv_seq_ctrl

Interface
REQ-001 SHALL have parameter MAC_IN_NUM, default 9, input lanes per MAC column.
REQ-002 SHALL have parameter MAC_OUT_NUM, default 18, output channels per block.
REQ-003 SHALL have parameter CNT_WIDTH, default 10, width of the loop counters and config fields.
REQ-004 SHALL have parameter SCALE_WIDTH, default 4, width of the requant shift.
REQ-005 SHALL have parameter MULT_PIPELINE_STAGE, default 2, multiplier pipeline depth.
REQ-006 SHALL have parameter CONV_STATE, default 3'd2, top-state code that enables convolution.
REQ-007 SHALL have ports, one per line:
  clk  in  1  single clock, rising edge.
  rst  in  1  asynchronous, active-high reset.
  current_state  in  3  top-level state.
  cfg_ic_blk  in  CNT_WIDTH  input-channel blocks minus 1.
  cfg_oc_blk  in  CNT_WIDTH  output-channel blocks minus 1.
  cfg_pix  in  CNT_WIDTH  output pixels minus 1.
  cfg_scale  in  SCALE_WIDTH  requant shift.
  fm_valid  in  1  feature data available.
  out_ready  in  1  writeback can accept.
  mac_en  out  1  MAC array enable this cycle.
  adder_rst  out  1  clear accumulator on this beat.
  acc_valid  out  1  accumulated result present at the MAC output.
  scale_in  out  SCALE_WIDTH  shift applied to acc_valid result.
  ic_cnt, pix_cnt, oc_cnt  out  CNT_WIDTH each  current loop indices (buffer addressing).
  busy  out  1  FSM not IDLE.
  state_end  out  1  one-cycle completion pulse.

Function
REQ-008 SHALL implement FSM IDLE -> LOAD -> RUN -> DRAIN -> DONE -> IDLE.
REQ-009 IDLE -> LOAD when current_state==CONV_STATE; LOAD lasts exactly 1 cycle and latches all cfg_* inputs; cfg changes after LOAD SHALL be ignored.
REQ-010 Loop order, innermost first: ic_cnt 0..cfg_ic_blk, then pix_cnt 0..cfg_pix, then oc_cnt 0..cfg_oc_blk; counters SHALL advance only on cycles with mac_en=1.
REQ-011 mac_en = (state==RUN) & fm_valid & out_ready, combinational from registered state.
REQ-012 adder_rst SHALL be 1 exactly on mac_en beats where ic_cnt==0.
REQ-013 On the mac_en beat with ic_cnt==cfg_ic_blk, a token SHALL enter a delay line of MULT_PIPELINE_STAGE+1 stages; its output is acc_valid; scale_in SHALL equal the latched cfg_scale.
REQ-014 The delay line SHALL shift every cycle regardless of stalls.
REQ-015 RUN -> DRAIN on the mac_en beat where all three counters are at their terminal values; counters SHALL wrap to 0 on that beat.
REQ-016 DRAIN SHALL last MULT_PIPELINE_STAGE+1 cycles, so the final acc_valid is emitted before DONE.
REQ-017 DONE SHALL pulse state_end for 1 cycle, then return to IDLE; a new LOAD SHALL require current_state to leave and then re-enter CONV_STATE.
REQ-018 cfg value 0 in any field SHALL mean one iteration; all-zero config SHALL produce exactly one mac_en beat, with adder_rst=1 on that beat and one acc_valid.
REQ-019 fm_valid or out_ready low during RUN SHALL hold all counters and FSM, with no lost or duplicated beats.

Reset
REQ-020 While rst=1, the block SHALL be asynchronously in IDLE with every output 0 (including scale_in and the counters), the delay line cleared, and the latched config zeroed.
REQ-021 rst asserted mid-RUN or mid-DRAIN SHALL drop any in-flight acc_valid tokens; no state_end SHALL follow.

Configuration
REQ-022 Macro CONV_CTRL_ABORT_EN defined: current_state!=CONV_STATE during LOAD, RUN or DRAIN SHALL force IDLE next cycle. This clears the counters and delay line, and state_end SHALL NOT pulse.
REQ-023 Macro CONV_CTRL_ABORT_EN undefined: current_state SHALL be ignored outside IDLE and DONE.

Verification
REQ-024 Basic run: cfg_ic_blk=2, cfg_pix=1, cfg_oc_blk=0, fm_valid=out_ready=1 -> required response:
  - 6 mac_en beats;
  - adder_rst on beats 1 and 4;
  - acc_valid 3 cycles after beats 3 and 6;
  - state_end once.
REQ-025 Stall: same config, fm_valid low for 4 cycles after beat 2 -> counters hold, still exactly 6 beats, and state_end 4 cycles later than in REQ-024.
REQ-026 Minimum config: all cfg=0, cfg_scale=5 -> 1 beat with adder_rst=1, one acc_valid with scale_in=5, then state_end.
REQ-027 Reset mid-run: rst asserted at beat 3 -> all outputs 0 immediately, no acc_valid afterwards, FSM in IDLE.
REQ-028 Abort: current_state changed at beat 2 -> with CONV_CTRL_ABORT_EN, IDLE next cycle and no state_end; without it, the run completes with state_end.
